// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN constants (pixel width, per-layer map sizes) and read-FSM state type
package cnn_pkg;
  localparam int FMAP_DATA_BITS = 12;
  localparam int L1_WIDTH = 12;
  localparam int L1_HEIGHT = 12;
  localparam int L2_WIDTH = 6;
  localparam int L2_HEIGHT = 6;
  typedef enum logic {IDLE, STREAM} rd_state_e;
endpackage

// File: rtl/fmap_bank_ram.sv
// fmap_bank_ram: simple dual-port frame bank, synchronous read, contents never reset
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out one cycle later.
module fmap_bank_ram #(
  parameter int DEPTH = 144,
  parameter int DATA_BITS = 12
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_BITS-1:0]     wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_BITS-1:0]     rdata
);
  logic [DATA_BITS-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: ping-pong frame buffer turning sparse raster input into dense framed output
// Ports: clk, rst_n (async, active-low); valid_in/data_in raster pixels in;
// valid_out/data_out dense pixels out with frame_start/line_end/frame_end markers;
// overflow pulses one cycle per dropped input pixel.
module fmap_stream_tx import cnn_pkg::*; #(
  parameter int WIDTH = L1_WIDTH,
  parameter int HEIGHT = L1_HEIGHT,
  parameter int DATA_BITS = FMAP_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 valid_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_start,
  output logic                 line_end,
  output logic                 frame_end,
  output logic                 overflow
);
  localparam int N = WIDTH * HEIGHT;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(WIDTH);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  rd_state_e state;
  logic [1:0] full;
  logic wr_bank, rd_bank, rd_sel;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [CW-1:0] col;
  logic [DATA_BITS-1:0] q0, q1;
  logic accept, wr_last, rd_en, rd_last;
  assign accept = valid_in && !full[wr_bank];
  assign wr_last = accept && wr_addr == LAST;
  assign rd_en = state == STREAM;
  assign rd_last = rd_en && rd_addr == LAST;
  // RAM output has no reset, so gate it to keep data_out at zero outside valid cycles
  assign data_out = valid_out ? (rd_sel ? q1 : q0) : '0;
  fmap_bank_ram #(.DEPTH(N), .DATA_BITS(DATA_BITS)) u_bank0 (
    .clk(clk), .we(accept && !wr_bank), .waddr(wr_addr), .wdata(data_in),
    .raddr(rd_addr), .rdata(q0)
  );
  fmap_bank_ram #(.DEPTH(N), .DATA_BITS(DATA_BITS)) u_bank1 (
    .clk(clk), .we(accept && wr_bank), .waddr(wr_addr), .wdata(data_in),
    .raddr(rd_addr), .rdata(q1)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      wr_bank <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= valid_in && full[wr_bank];
      if (accept) wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
      if (wr_last) wr_bank <= !wr_bank;
    end
  end
  // A bank is never set and released in the same cycle: writes need it empty, reads need it full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full <= '0;
    else full <= (full | ({wr_bank, !wr_bank} & {2{wr_last}}))
               & ~({rd_bank, !rd_bank} & {2{rd_last}});
  end
  // Markers are computed from the issued address so they line up with the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_bank <= 1'b0;
      rd_sel <= 1'b0;
      rd_addr <= '0;
      col <= '0;
      valid_out <= 1'b0;
      frame_start <= 1'b0;
      line_end <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      valid_out <= rd_en;
      frame_start <= rd_en && rd_addr == '0;
      line_end <= rd_en && col == COL_LAST;
      frame_end <= rd_last;
      rd_sel <= rd_bank;
      if (state == IDLE) begin
        rd_addr <= '0;
        col <= '0;
        if (full[rd_bank]) state <= STREAM;
      end else begin
        rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
        col <= col == COL_LAST ? '0 : col + 1'b1;
        if (rd_last) begin
          rd_bank <= !rd_bank;
          if (!full[!rd_bank]) state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_fmap_stream_tx.sv
// tb_fmap_stream_tx: directed checks of framing, latency, back-to-back frames, overflow and reset
module tb_fmap_stream_tx;
  typedef struct {int d; bit fs; bit le; bit fe; int c;} px_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic [11:0] data_in = '0;
  logic valid_out, frame_start, line_end, frame_end, overflow;
  logic [11:0] data_out;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int last_k;
  int ovf_n = 0;
  int ovf_cyc = -1;
  px_t q[$];
  fmap_stream_tx #(.WIDTH(12), .HEIGHT(12), .DATA_BITS(12)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out), .frame_start(frame_start),
    .line_end(line_end), .frame_end(frame_end), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid_out) q.push_back('{int'(data_out), frame_start, line_end, frame_end, cyc});
    if (overflow) begin
      if (ovf_n == 0) ovf_cyc = cyc;
      ovf_n++;
    end
  end
  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  // n pixels, gap idle cycles after each; frame f pixel p carries base + 1000*f + p
  task automatic send(input int base, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in = 12'(base + 1000 * (i / 144) + i % 144);
      last_k = cyc + 1;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        valid_in = 1'b0;
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask
  task automatic wait_out(input string tag, input int n);
    for (int i = 0; i < 600 && q.size() < n; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    check({tag, "_count"}, q.size(), n);
  endtask
  task automatic check_frame(input string tag, input int start, input int base, input int first);
    int ed, ef, eg;
    ed = 0; ef = 0; eg = 0;
    if (q.size() >= start + 144) begin
      for (int i = 0; i < 144; i++) begin
        ed += int'(q[start+i].d != base + i);
        ef += int'(q[start+i].fs != (i == 0)) + int'(q[start+i].le != (i % 12 == 11))
            + int'(q[start+i].fe != (i == 143));
        eg += int'(q[start+i].c != first + i);
      end
    end else ed = 144;
    check({tag, "_data_errs"}, ed, 0);
    check({tag, "_flag_errs"}, ef, 0);
    check({tag, "_timing_errs"}, eg, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_line_end", line_end, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_overflow", overflow, 0);
    send(0, 144, 0);
    wait_out("dense", 144);
    check_frame("dense", 0, 0, last_k + 2);
    q.delete();
    send(0, 144, 2);
    wait_out("sparse", 144);
    check_frame("sparse", 0, 0, last_k + 2);
    q.delete();
    send(0, 288, 0);
    wait_out("b2b", 288);
    check_frame("b2b_f0", 0, 0, last_k - 144 + 2);
    check_frame("b2b_f1", 144, 1000, last_k - 144 + 146);
    check("b2b_overflow", ovf_n, 0);
    q.delete();
    send(500, 144, 0);
    for (int i = 0; i < 100 && cyc < last_k + 72; i++) @(negedge clk);
    check("pre_rst_valid", valid_out, 1);
    check("pre_rst_pixel70", data_out, 570);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid_out", valid_out, 0);
    check("async_data_out", data_out, 0);
    check("async_frame_start", frame_start, 0);
    check("async_line_end", line_end, 0);
    check("async_frame_end", frame_end, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    send(3000, 144, 0);
    wait_out("post_rst", 144);
    check_frame("post_rst", 0, 3000, last_k + 2);
    q.delete();
    ovf_n = 0;
    ovf_cyc = -1;
    send(0, 432, 0);
    wait_out("ovf", 288);
    check_frame("ovf_f0", 0, 0, last_k - 288 + 2);
    check_frame("ovf_f1", 144, 1000, last_k - 288 + 146);
    check("ovf_pulses", ovf_n, 1);
    check("ovf_cycle", ovf_cyc, last_k - 143);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
